// File: rtl/multimode_counter_gen_if.sv
// multimode_counter_gen_if: control/status bundle for multimode_counter_gen
// master drives en/mode/load/load_val/lo_lim/hi_lim/step and observes count/dir/at_limit/wrap/cfg_err
// slave is the counter side of the same bundle
interface multimode_counter_gen_if #(
  parameter int WIDTH = 8,
  parameter int STEP_W = 4
);
  logic en;
  logic [2:0] mode;
  logic load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] lo_lim;
  logic [WIDTH-1:0] hi_lim;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0] count;
  logic dir;
  logic at_limit;
  logic wrap;
  logic cfg_err;
  modport master (
    output en, mode, load, load_val, lo_lim, hi_lim, step,
    input count, dir, at_limit, wrap, cfg_err
  );
  modport slave (
    input en, mode, load, load_val, lo_lim, hi_lim, step,
    output count, dir, at_limit, wrap, cfg_err
  );
endinterface

// File: rtl/multimode_counter_gen.sv
// multimode_counter_gen: parametrised saturating/ping-pong/wrapping counter with registered status
// clk, rst_n (async, active-low); bus: multimode_counter_gen_if.slave carrying
//   en, mode, load, load_val, lo_lim, hi_lim, step in; count, dir, at_limit, wrap, cfg_err out
// Optional MMC_PRESCALE_EN: adds PRE_W and prescale input; a step happens every (prescale+1)-th en cycle
module multimode_counter_gen #(
  parameter int WIDTH = 8,
  parameter int STEP_W = 4
`ifdef MMC_PRESCALE_EN
  , parameter int PRE_W = 8
`endif
) (
  input logic clk,
  input logic rst_n,
`ifdef MMC_PRESCALE_EN
  input logic [PRE_W-1:0] prescale,
`endif
  multimode_counter_gen_if.slave bus
);
  logic [WIDTH-1:0] count_q;
  logic dir_q, at_q, wrap_q, err_q;
  logic [WIDTH:0] c, l, h, s, up, lo_s, range_w, excess, deficit, up_sat, dn_sat, res;
  logic cfg, tick, go, oor;
  logic nxt_dir, nxt_at, nxt_wrap;
  // everything is widened by one bit so sums and differences never wrap silently
  assign c = {1'b0, count_q};
  assign l = {1'b0, bus.lo_lim};
  assign h = {1'b0, bus.hi_lim};
  assign s = (WIDTH+1)'(bus.step);
  assign up = c + s;
  assign lo_s = l + s;
  assign range_w = h - l + 1'b1;
  assign excess = up - h - 1'b1;
  assign deficit = lo_s - c - 1'b1;
  assign up_sat = up > h ? h : up;
  assign dn_sat = c >= lo_s ? c - s : l;
  assign cfg = bus.lo_lim > bus.hi_lim;
  assign oor = c < l || c > h;
`ifdef MMC_PRESCALE_EN
  logic [PRE_W-1:0] pcnt;
  assign tick = bus.en && pcnt == prescale;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pcnt <= '0;
    else if (bus.load) pcnt <= '0;
    else if (bus.en) pcnt <= tick ? '0 : pcnt + 1'b1;
`else
  assign tick = bus.en;
`endif
  assign go = tick && |bus.step && bus.mode <= 3'd4 && !cfg;
  // excess/deficit are always below step, so the modulo reduces to a plain
  // offset when range > step; otherwise the result clamps to the far bound
  always_comb begin
    res = c;
    nxt_dir = dir_q;
    nxt_at = 1'b0;
    nxt_wrap = 1'b0;
    if (bus.load) res = {1'b0, bus.load_val};
    else if (go && oor) res = (bus.mode == 3'd1 || bus.mode == 3'd4 || (bus.mode == 3'd2 && !dir_q)) ? h : l;
    else if (go) begin
      case (bus.mode)
        3'd0: begin
          nxt_at = c == h;
          res = up_sat;
        end
        3'd1: begin
          nxt_at = c == l;
          res = dn_sat;
        end
        3'd2: begin
          nxt_at = dir_q ? c == h : c == l;
          nxt_dir = nxt_at ? !dir_q : dir_q;
          res = dir_q ? up_sat : dn_sat;
        end
        3'd3: begin
          nxt_wrap = up > h;
          res = !nxt_wrap ? up : range_w > s ? l + excess : l;
        end
        3'd4: begin
          nxt_wrap = c < lo_s;
          res = !nxt_wrap ? c - s : range_w > s ? h - deficit : h;
        end
        default: res = c;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count_q <= '0;
      dir_q <= 1'b1;
      at_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      count_q <= WIDTH'(res);
      dir_q <= nxt_dir;
      at_q <= nxt_at;
      wrap_q <= nxt_wrap;
      err_q <= cfg;
    end
  assign bus.count = count_q;
  assign bus.dir = dir_q;
  assign bus.at_limit = at_q;
  assign bus.wrap = wrap_q;
  assign bus.cfg_err = err_q;
endmodule

// File: tb/tb_multimode_counter_gen.sv
// tb_multimode_counter_gen: directed vector table, async reset sequence and randomized model check
module tb_multimode_counter_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int m_count;
  logic m_dir, m_at, m_wrap, m_err;
  typedef struct {
    logic ld;
    logic en;
    logic [2:0] md;
    logic [7:0] lv;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] st;
    logic [7:0] ec;
    logic ed;
    logic ea;
    logic ew;
    logic ee;
  } vec_t;
  vec_t tv[$];
  multimode_counter_gen_if #(.WIDTH(8), .STEP_W(4)) bus ();
  multimode_counter_gen #(.WIDTH(8), .STEP_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef MMC_PRESCALE_EN
    .prescale(8'd0),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(input int ld, en, md, lv, lo, hi, st, ec, ed, ea, ew, ee);
    vec_t r;
    r.ld = ld[0]; r.en = en[0]; r.md = md[2:0]; r.lv = lv[7:0]; r.lo = lo[7:0];
    r.hi = hi[7:0]; r.st = st[3:0]; r.ec = ec[7:0]; r.ed = ed[0]; r.ea = ea[0];
    r.ew = ew[0]; r.ee = ee[0];
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_all(input string tag, input int ec, input logic ed, ea, ew, ee);
    chk({tag, " count"}, 32'(bus.count), 32'(ec));
    chk({tag, " dir"}, 32'(bus.dir), 32'(ed));
    chk({tag, " at_limit"}, 32'(bus.at_limit), 32'(ea));
    chk({tag, " wrap"}, 32'(bus.wrap), 32'(ew));
    chk({tag, " cfg_err"}, 32'(bus.cfg_err), 32'(ee));
  endtask
  task automatic drive(input logic ld, en, input int md, lv, lo, hi, st);
    bus.load = ld; bus.en = en; bus.mode = md[2:0]; bus.load_val = lv[7:0];
    bus.lo_lim = lo[7:0]; bus.hi_lim = hi[7:0]; bus.step = st[3:0];
  endtask
  // reference: the counter's rules computed directly on integers
  task automatic model(input logic ld, en, input int md, lv, lo, hi, st);
    int rng;
    m_at = 1'b0;
    m_wrap = 1'b0;
    m_err = lo > hi;
    rng = hi - lo + 1;
    if (ld) m_count = lv;
    else if (lo > hi || !en || st == 0 || md > 4) m_count = m_count;
    else if (m_count < lo || m_count > hi) begin
      if (md == 1 || md == 4 || (md == 2 && !m_dir)) m_count = hi;
      else m_count = lo;
    end else begin
      case (md)
        0: if (m_count == hi) m_at = 1'b1; else m_count = (m_count + st > hi) ? hi : m_count + st;
        1: if (m_count == lo) m_at = 1'b1; else m_count = (m_count - st < lo) ? lo : m_count - st;
        2: if (m_dir) begin
             if (m_count == hi) begin m_dir = 1'b0; m_at = 1'b1; end
             else m_count = (m_count + st > hi) ? hi : m_count + st;
           end else begin
             if (m_count == lo) begin m_dir = 1'b1; m_at = 1'b1; end
             else m_count = (m_count - st < lo) ? lo : m_count - st;
           end
        3: if (m_count + st <= hi) m_count = m_count + st;
           else begin
             m_wrap = 1'b1;
             m_count = (rng <= st) ? lo : lo + ((m_count + st - hi - 1) % rng);
           end
        4: if (m_count - st >= lo) m_count = m_count - st;
           else begin
             m_wrap = 1'b1;
             m_count = (rng <= st) ? hi : hi - ((lo - (m_count - st) - 1) % rng);
           end
        default: m_count = m_count;
      endcase
    end
  endtask
  initial begin
    int lo, hi, md;
    logic ld, en;
    tv.push_back(v(0,1,0,0,0,10,3, 3,1,0,0,0));
    tv.push_back(v(0,1,0,0,0,10,3, 6,1,0,0,0));
    tv.push_back(v(0,1,0,0,0,10,3, 9,1,0,0,0));
    tv.push_back(v(0,1,0,0,0,10,3, 10,1,0,0,0));
    tv.push_back(v(0,1,0,0,0,10,3, 10,1,1,0,0));
    tv.push_back(v(0,1,0,0,0,10,3, 10,1,1,0,0));
    tv.push_back(v(1,1,2,2,2,5,1, 2,1,0,0,0));
    tv.push_back(v(0,1,2,0,2,5,1, 3,1,0,0,0));
    tv.push_back(v(0,1,2,0,2,5,1, 4,1,0,0,0));
    tv.push_back(v(0,1,2,0,2,5,1, 5,1,0,0,0));
    tv.push_back(v(0,1,2,0,2,5,1, 5,0,1,0,0));
    tv.push_back(v(0,1,2,0,2,5,1, 4,0,0,0,0));
    tv.push_back(v(0,1,2,0,2,5,1, 3,0,0,0,0));
    tv.push_back(v(0,1,2,0,2,5,1, 2,0,0,0,0));
    tv.push_back(v(0,1,2,0,2,5,1, 2,1,1,0,0));
    tv.push_back(v(0,1,2,0,2,5,1, 3,1,0,0,0));
    tv.push_back(v(1,1,3,8,4,9,4, 8,1,0,0,0));
    tv.push_back(v(0,1,3,0,4,9,4, 6,1,0,1,0));
    tv.push_back(v(0,1,3,0,4,9,4, 4,1,0,1,0));
    tv.push_back(v(0,1,3,0,4,9,4, 8,1,0,0,0));
    tv.push_back(v(1,1,4,0,0,255,1, 0,1,0,0,0));
    tv.push_back(v(0,1,4,0,0,255,1, 255,1,0,1,0));
    tv.push_back(v(0,1,4,0,0,255,1, 254,1,0,0,0));
    tv.push_back(v(0,1,0,0,7,3,1, 254,1,0,0,1));
    tv.push_back(v(1,1,0,200,7,3,1, 200,1,0,0,1));
    tv.push_back(v(0,1,0,0,0,15,1, 0,1,0,0,0));
    tv.push_back(v(0,0,0,0,0,15,1, 0,1,0,0,0));
    tv.push_back(v(0,1,0,0,0,15,0, 0,1,0,0,0));
    tv.push_back(v(0,1,5,0,0,15,1, 0,1,0,0,0));
    tv.push_back(v(0,1,0,0,0,15,1, 1,1,0,0,0));
    tv.push_back(v(1,1,0,5,5,5,2, 5,1,0,0,0));
    tv.push_back(v(0,1,0,0,5,5,2, 5,1,1,0,0));
    tv.push_back(v(0,1,3,0,5,5,2, 5,1,0,1,0));
    tv.push_back(v(0,1,1,0,5,5,2, 5,1,1,0,0));
    tv.push_back(v(0,1,4,0,5,5,2, 5,1,0,1,0));
    tv.push_back(v(1,1,3,1,0,3,5, 1,1,0,0,0));
    tv.push_back(v(0,1,3,0,0,3,5, 0,1,0,1,0));
    tv.push_back(v(0,1,4,0,0,3,5, 3,1,0,1,0));
    tv.push_back(v(1,1,1,9,2,9,3, 9,1,0,0,0));
    tv.push_back(v(0,1,1,0,2,9,3, 6,1,0,0,0));
    tv.push_back(v(0,1,1,0,2,9,3, 3,1,0,0,0));
    tv.push_back(v(0,1,1,0,2,9,3, 2,1,0,0,0));
    tv.push_back(v(0,1,1,0,2,9,3, 2,1,1,0,0));
    tv.push_back(v(0,1,2,0,10,20,1, 10,1,0,0,0));
    drive(0, 0, 0, 0, 0, 0, 0);
    #12;
    chk_all("reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    foreach (tv[i]) begin
      drive(tv[i].ld, tv[i].en, tv[i].md, tv[i].lv, tv[i].lo, tv[i].hi, tv[i].st);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), tv[i].ec, tv[i].ed, tv[i].ea, tv[i].ew, tv[i].ee);
    end
    drive(1, 1, 2, 5, 2, 5, 1);
    @(posedge clk); #1;
    drive(0, 1, 2, 0, 2, 5, 1);
    @(posedge clk); #1;
    chk_all("pp reverse", 5, 1'b0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("pp down", 4, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async reset", 0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_count = 0; m_dir = 1'b1; m_at = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
    lo = 0; hi = 255;
    for (int k = 0; k < 600; k++) begin
      if (k % 16 == 0) begin
        lo = int'($urandom_range(0, 255));
        hi = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(lo, 255));
        if ($urandom_range(0, 3) == 0) hi = lo + int'($urandom_range(0, (lo > 247) ? 255 - lo : 8));
      end
      ld = $urandom_range(0, 11) == 0;
      en = $urandom_range(0, 4) != 0;
      md = int'($urandom_range(0, 7));
      drive(ld, en, md, int'($urandom_range(0, 255)), lo, hi, int'($urandom_range(0, 15)));
      model(ld, en, md, int'(bus.load_val), lo, hi, int'(bus.step));
      @(posedge clk); #1;
      chk_all($sformatf("rand%0d", k), m_count, m_dir, m_at, m_wrap, m_err);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
